// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div with fixed latency
// and drives the busy flag consumed by the hazard controller.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] count;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_dz;

  logic          is_mult, is_div, is_signed;
  logic [63:0]   prod;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [31:0]   res_hi, res_lo;

  assign busy      = (count != '0);
  assign is_mult   = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  // Signed cases are handled by sign-extending (mult) or by working on
  // magnitudes (div); the latter makes 0x80000000 / -1 fall out naturally.
  assign prod = is_signed ? ({{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data})
                          : ({32'b0, rs_data} * {32'b0, rt_data});

  assign a_neg  = is_signed && rs_data[31];
  assign b_neg  = is_signed && rt_data[31];
  assign a_mag  = a_neg ? (~rs_data + 32'd1) : rs_data;
  assign b_mag  = b_neg ? (~rt_data + 32'd1) : rt_data;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign res_hi = is_div ? rem  : prod[63:32];
  assign res_lo = is_div ? quot : prod[31:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else if (count != '0) begin
      count <= count - CW'(1);
      if (count == CW'(1) && !pend_dz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start && (is_mult || is_div)) begin
      count   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_dz <= is_div && (rt_data == 32'd0);
    end else if (op == OP_MTHI) begin
      hi <= rs_data;
    end else if (op == OP_MTLO) begin
      lo <= rs_data;
    end
  end

  // NOTE: rd_out gets a default before the case so no latch is inferred
  // for the ops that do not read HI/LO.
  always_comb begin
    rd_out = '0;
    case (op)
      OP_MFHI: rd_out = hi;
      OP_MFLO: rd_out = lo;
      default: rd_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard of
// expected HI/LO commits, with hand sequences for the multi-cycle corners.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, busy;
  logic [3:0]  op;
  logic [31:0] rs_data, rt_data, hi, lo, rd_out;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, exp_hi, exp_lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } res_t;

  vec_t        vecs[11];
  res_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic write_hilo(input logic [3:0] wop, input logic [31:0] val);
    @(negedge clk);
    start = 1'b0; op = wop; rs_data = val;
    @(negedge clk);
    op = 4'd0; rs_data = '0;
    if (wop == 4'd7) model_hi = val; else model_lo = val;
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic compare_result(input string name);
    res_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({name, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
      check({name, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int cycles;
    @(negedge clk);
    start = 1'b1; op = v.op; rs_data = v.rs; rt_data = v.rt;
    if (v.dz) sb.push_back('{model_hi, model_lo});
    else      sb.push_back('{v.exp_hi, v.exp_lo});
    @(negedge clk);
    start = 1'b0; op = 4'd0; rs_data = '0; rt_data = '0;
    count_busy(cycles);
    check({name, "_busy_cycles"}, 64'(cycles), (v.op <= 4'd2) ? 64'(MC) : 64'(DC));
    compare_result(name);
    op = 4'd6; #1;
    check({name, "_mflo"}, {32'b0, rd_out}, {32'b0, model_lo});
    op = 4'd5; #1;
    check({name, "_mfhi"}, {32'b0, rd_out}, {32'b0, model_hi});
    op = 4'd0;
  endtask

  initial begin
    int cycles, busy_seen;
    vec_t dzv;

    vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[2]  = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[3]  = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[4]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[5]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'd2,        32'hFFFFFFFA, 1'b0};
    vecs[6]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[7]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{4'd4, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0};
    vecs[9]  = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 1'b0};
    vecs[10] = '{4'd3, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0};

    reset = 1'b1; start = 1'b0; op = 4'd0; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    op = 4'd5; #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_mfhi", {32'b0, rd_out}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    op = 4'd0;

    write_hilo(4'd7, 32'h1234);
    check("mthi_hi", {32'b0, hi}, 64'h1234);
    op = 4'd5; #1;
    check("mthi_mfhi", {32'b0, rd_out}, 64'h1234);
    op = 4'd9; #1;
    check("other_op_rd_zero", {32'b0, rd_out}, 64'd0);
    op = 4'd0;

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    write_hilo(4'd7, 32'hAA);
    write_hilo(4'd8, 32'hBB);
    dzv = '{4'd4, 32'd123, 32'd0, 32'd0, 32'd0, 1'b1};
    run_op(dzv, "divu_zero");
    dzv.op = 4'd3;
    run_op(dzv, "div_zero");

    // Starts and moves issued while busy must not disturb the mult in flight.
    @(negedge clk);
    start = 1'b1; op = 4'd1; rs_data = 32'd5; rt_data = 32'd6;
    sb.push_back('{32'd0, 32'd30});
    @(negedge clk);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (cycles == 1) begin
        start = 1'b1; op = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
      end else if (cycles == 2) begin
        start = 1'b0; op = 4'd8; rs_data = 32'hDEAD;
      end else begin
        start = 1'b0; op = 4'd0; rs_data = '0; rt_data = '0;
      end
      @(negedge clk);
    end
    start = 1'b0; op = 4'd0;
    check("viol_busy_cycles", 64'(cycles), 64'(MC));
    compare_result("viol");
    repeat (2) @(negedge clk);
    check("viol_no_late_div", {63'b0, busy}, 64'd0);

    // Asynchronous reset in the third busy cycle of a divide.
    @(negedge clk);
    start = 1'b1; op = 4'd4; rs_data = 32'd7; rt_data = 32'd2;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {63'b0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", {63'b0, busy}, 64'd0);
    check("async_reset_hi", {32'b0, hi}, 64'd0);
    check("async_reset_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("post_reset_busy_seen", 64'(busy_seen), 64'd0);
    check("post_reset_hi", {32'b0, hi}, 64'd0);
    check("post_reset_lo", {32'b0, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- EX-stage multiply/divide unit of the pipelined MIPS core; owns the HI/LO registers.
- Drives the busy flag that the hazard controller consumes.
- The hazard controller stalls any mult/div-class instruction in ID while this unit's `start` or `busy` is high; this block is the producer side of that start/busy handshake.
- Executes mult/multu/div/divu with fixed multi-cycle latency, applies mthi/mtlo writes, and provides mfhi/mflo read data.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high after a mult/multu start (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high after a div/divu start (≥1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: EX instruction is mult/multu/div/divu; sampled with `op`
- op  input  4  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mfhi, 6=mflo, 7=mthi, 8=mtlo; others = none
- rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo source)
- rt_data  input  32  forwarded rt operand (divisor / multiplier)
- busy  output  1  operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- rd_out  output  32  mfhi/mflo result for EX writeback

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi=0, lo=0, busy=0, cycle counter=0.
  - Pending result is discarded; no HI/LO commit follows reset release.
- Counter:
  - Internal down-counter, width ≥ clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
  - busy = (counter != 0), combinational from the counter.
- Start edge: `start`=1, counter==0, op ∈ {1..4}:
  - Compute the result from rs_data/rt_data and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (op 1, 2) or DIV_CYCLES (op 3, 4).
  - busy rises in the cycle after the start edge and stays high exactly N cycles.
- Arithmetic:
  - mult: signed 32x32 → 64; pending_hi = [63:32], pending_lo = [31:0].
  - multu: unsigned 32x32 → 64.
  - div: signed; pending_lo = quotient truncated toward zero, pending_hi = remainder with the dividend's sign. 0x80000000 / -1 → lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt_data==0, div or divu): no HI/LO commit. busy timing is unchanged (DIV_CYCLES cycles).
- Counting:
  - Each edge with counter != 0: counter decrements.
  - On the edge where counter goes 1→0: hi<=pending_hi, lo<=pending_lo (unless divide-by-zero).
  - In the first cycle with busy=0, hi/lo already show the new values.
- Ignored starts:
  - `start` with counter != 0: ignored; the in-flight op is unaffected (protocol violation; hazard unit prevents it).
  - `start` with op ∉ {1..4}: ignored.
- mthi (op 7) / mtlo (op 8):
  - When busy=0: hi (resp. lo) <= rs_data on that edge; `start` is not required.
  - When busy=1: ignored.
  - A simultaneous mult/div start cannot occur (single op field).
- mfhi (op 5) / mflo (op 6): rd_out = hi (resp. lo), combinational, current register value.
  - rd_out = 0 for every other op.
  - rd_out is valid only when busy=0; the hazard unit guarantees this.
- Latency summary:
  - Start sampled at edge E0; busy high for cycles E0+1 … E0+N; HI/LO updated at edge E0+N.
  - A back-to-back start is accepted at edge E0+N (counter==0 at that edge? no: counter==1) — the next start is accepted at the first edge where counter==0, i.e. E0+N+1 at the earliest, when ID issue is unstalled.

Test Plan:
- Reset release, op=5 → rd_out=0, busy=0. Then op=7, rs=0x1234 → next cycle hi=0x1234; op=5 gives rd_out=0x1234.
- start, op=1, rs=0xFFFFFFFE (-2), rt=3 → busy=1 for exactly 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA; op=6 gives 0xFFFFFFFA.
- start, op=3, rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles. Then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with op=4, rs=7, rt=2 → lo=3, hi=1.
- Divide by zero: preset hi=0xAA, lo=0xBB; start op=4, rt=0 → busy 10 cycles; hi/lo remain 0xAA/0xBB.
- Busy violations: during a mult, pulse start op=3 and op=8 → both ignored; busy still drops after 5 cycles and the mult result commits.
- Reset asserted in cycle 3 of a div → busy=0, hi=lo=0 immediately (asynchronous). After release, no commit occurs and busy stays 0.
